// File: rtl/halt_request_controller.sv
// rtl/halt_request_controller.sv - stalls the CPU clock while a data access runs on the bus.
// A request in IDLE raises halt combinationally; the CPU sees one gated edge in DONE.
module halt_request_controller #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_sel,
  output logic        halt,
  output logic [31:0] cpu_rdata,
  output logic        timeout_err,
  output logic        bus_cyc,
  output logic        bus_we,
  output logic [31:0] bus_adr,
  output logic [31:0] bus_dat_o,
  output logic [3:0]  bus_sel,
  input  logic        bus_ack,
  input  logic [31:0] bus_dat_i
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] count;
  logic       req;
  logic       start;
  logic       ack_done;
  logic       abort;

  assign req  = cpu_read | cpu_write;
  assign halt = !reset && (((state == IDLE) && req) || (state == BUSY));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // An ack arriving on the final timeout cycle takes priority over the abort.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    ack_done   = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          start      = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (bus_ack) begin
          ack_done   = 1'b1;
          state_next = DONE;
        end else if (count == LAST_COUNT) begin
          abort      = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count       <= 8'd0;
      bus_cyc     <= 1'b0;
      bus_we      <= 1'b0;
      bus_adr     <= 32'd0;
      bus_dat_o   <= 32'd0;
      bus_sel     <= 4'd0;
      cpu_rdata   <= 32'd0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      if (start) begin
        count     <= 8'd0;
        bus_cyc   <= 1'b1;
        bus_we    <= cpu_write;
        bus_adr   <= {cpu_addr[31:2], 2'b00};
        bus_dat_o <= cpu_wdata;
        bus_sel   <= cpu_sel;
      end else if (ack_done) begin
        bus_cyc <= 1'b0;
        if (!bus_we) begin
          cpu_rdata <= bus_dat_i;
        end
      end else if (abort) begin
        bus_cyc     <= 1'b0;
        timeout_err <= 1'b1;
        if (!bus_we) begin
          cpu_rdata <= 32'd0;
        end
      end else if (state == BUSY) begin
        count <= count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_halt_request_controller.sv
// tb/tb_halt_request_controller.sv - scoreboard bench for halt_request_controller.
// Stimulus pushes expected access results; a negedge monitor checks each DONE cycle.
module tb_halt_request_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_sel;
  logic        halt;
  logic [31:0] cpu_rdata;
  logic        timeout_err;
  logic        bus_cyc;
  logic        bus_we;
  logic [31:0] bus_adr;
  logic [31:0] bus_dat_o;
  logic [3:0]  bus_sel;
  logic        bus_ack;
  logic [31:0] bus_dat_i;

  halt_request_controller #(.TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_read    (cpu_read),
    .cpu_write   (cpu_write),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_sel     (cpu_sel),
    .halt        (halt),
    .cpu_rdata   (cpu_rdata),
    .timeout_err (timeout_err),
    .bus_cyc     (bus_cyc),
    .bus_we      (bus_we),
    .bus_adr     (bus_adr),
    .bus_dat_o   (bus_dat_o),
    .bus_sel     (bus_sel),
    .bus_ack     (bus_ack),
    .bus_dat_i   (bus_dat_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        terr;
    int          halt_n;
    int          cyc_n;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [3:0]  sel;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model_rdata = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: counts halt/bus_cyc cycles per access and checks results in DONE.
  int   halt_run = 0;
  int   cyc_run = 0;
  logic bus_bad = 1'b0;
  logic after_done = 1'b0;
  exp_t e;

  always @(negedge clk) begin
    if (reset) begin
      halt_run   = 0;
      cyc_run    = 0;
      bus_bad    = 1'b0;
      after_done = 1'b0;
    end else begin
      if (after_done) begin
        chk("timeout_err_pulse", {31'd0, timeout_err}, 32'd0);
        after_done = 1'b0;
      end
      if (bus_cyc && exp_q.size() > 0) begin
        if (bus_we !== exp_q[0].we || bus_adr !== exp_q[0].adr ||
            bus_dat_o !== exp_q[0].wdata || bus_sel !== exp_q[0].sel)
          bus_bad = 1'b1;
      end
      if (halt) halt_run++;
      if (bus_cyc) cyc_run++;
      if (!halt && halt_run > 0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("cpu_rdata", cpu_rdata, e.rdata);
          chk("timeout_err", {31'd0, timeout_err}, {31'd0, e.terr});
          chk("halt_cycles", 32'(halt_run), 32'(e.halt_n));
          chk("bus_cyc_cycles", 32'(cyc_run), 32'(e.cyc_n));
          chk("bus_fields", {31'd0, bus_bad}, 32'd0);
        end
        halt_run   = 0;
        cyc_run    = 0;
        bus_bad    = 1'b0;
        after_done = 1'b1;
      end
    end
  end

  // Entered at posedge+1 of an IDLE cycle; returns at posedge+1 of the following IDLE cycle.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] sel,
                           input int ack_at, input logic [31:0] dat, input bit keep);
    exp_t x;
    int   n;
    n = (ack_at > 0) ? ack_at : 16;
    if (!wr) model_rdata = (ack_at > 0) ? dat : 32'd0;
    x.rdata  = model_rdata;
    x.terr   = (ack_at == 0);
    x.halt_n = n + 1;
    x.cyc_n  = n;
    x.we     = wr;
    x.adr    = {addr[31:2], 2'b00};
    x.wdata  = wdata;
    x.sel    = sel;
    exp_q.push_back(x);
    cpu_read  = rd;
    cpu_write = wr;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_sel   = sel;
    @(posedge clk); #1;
    for (int k = 1; k <= n; k++) begin
      bus_ack   = (k == ack_at);
      bus_dat_i = (k == ack_at) ? dat : 32'hA5A5_0000 + 32'(k);
      @(posedge clk); #1;
    end
    bus_ack = 1'b0;
    @(posedge clk); #1;
    if (!keep) begin
      cpu_read  = 1'b0;
      cpu_write = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    cpu_read  = 1'b1;
    cpu_write = 1'b0;
    cpu_addr  = 32'h0000_0040;
    cpu_wdata = 32'd0;
    cpu_sel   = 4'hF;
    bus_ack   = 1'b0;
    bus_dat_i = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_halt", {31'd0, halt}, 32'd0);
    chk("reset_bus_cyc", {31'd0, bus_cyc}, 32'd0);
    chk("reset_bus_adr", bus_adr, 32'd0);
    chk("reset_bus_we_sel", {27'd0, bus_we, bus_sel}, 32'd0);
    chk("reset_bus_dat_o", bus_dat_o, 32'd0);
    chk("reset_cpu_rdata", cpu_rdata, 32'd0);
    chk("reset_timeout_err", {31'd0, timeout_err}, 32'd0);
    cpu_read = 1'b0;
    reset    = 1'b0;
    @(posedge clk); #1;

    // Read, ack on 2nd BUSY cycle
    do_access(1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'hF, 2, 32'hCAFE_0001, 1'b0);
    // Write to unaligned address, ack on 1st BUSY cycle
    do_access(1'b0, 1'b1, 32'h0000_1003, 32'h1234_5678, 4'b0011, 1, 32'hDEAD_BEEF, 1'b0);
    // Read timing out
    do_access(1'b1, 1'b0, 32'h0000_3004, 32'h0, 4'hF, 0, 32'h0, 1'b0);
    // Ack on the 16th BUSY cycle beats the timeout
    do_access(1'b1, 1'b0, 32'h0000_3008, 32'h0, 4'b1100, 16, 32'h5555_AAAA, 1'b0);
    // Read and write together act as a write
    do_access(1'b1, 1'b1, 32'h0000_400E, 32'h8765_4321, 4'b0100, 1, 32'h1111_2222, 1'b0);

    // Stray acks in IDLE are ignored
    bus_ack   = 1'b1;
    bus_dat_i = 32'hFFFF_FFFF;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("idle_ack_bus_cyc", {31'd0, bus_cyc}, 32'd0);
    chk("idle_ack_rdata", cpu_rdata, model_rdata);
    bus_ack = 1'b0;

    // Back-to-back reads
    do_access(1'b1, 1'b0, 32'h0000_5000, 32'h0, 4'hF, 1, 32'h0102_0304, 1'b1);
    chk("b2b_halt_idle", {31'd0, halt}, 32'd1);
    do_access(1'b1, 1'b0, 32'h0000_5004, 32'h0, 4'hF, 1, 32'h0506_0708, 1'b0);

    // Reset during the 3rd BUSY cycle, request held through release
    cpu_read = 1'b1;
    cpu_addr = 32'h0000_6000;
    repeat (3) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    chk("reset_busy_bus_cyc", {31'd0, bus_cyc}, 32'd0);
    chk("reset_busy_halt", {31'd0, halt}, 32'd0);
    chk("reset_busy_rdata", cpu_rdata, 32'd0);
    model_rdata = 32'd0;
    @(posedge clk); #1;
    reset = 1'b0;
    do_access(1'b1, 1'b0, 32'h0000_6000, 32'h0, 4'hF, 1, 32'h0BAD_F00D, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
